cmd_sched: RTL and testbench

- Sequences access to the shared command-execution bus: the `run`/`cmd` inputs and the `rsp` output of the target executors (tap_exe and its siblings).
- Arbitrates round-robin between N_REQ command sources, e.g. host link and automated threshold-scan engine.
- Issues one `run` pulse per accepted command, waits a fixed executor latency, and captures the executor response.
- Returns the response only to the requester that issued the command; the bus never carries two commands in flight.

---
 rtl/cmd_sched_pkg.sv | 14 +
 rtl/cmd_sched_rr_arb.sv | 34 +++
 rtl/cmd_sched.sv | 100 ++++++++++
 tb/tb_cmd_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command-execution bus scheduler:
// command width and FSM state encoding.
package cmd_sched_pkg;

    localparam int CMD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_sched_rr_arb.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above ptr, wrapping upward; returns a one-hot grant and its binary index.
module cmd_sched_rr_arb #(
    parameter int N_REQ = 2,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    int   pos;
    logic found;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (en && !found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/cmd_sched.sv
// Round-robin scheduler for the shared executor bus: one command in flight,
// fixed response latency, response returned only to the issuing requester.
module cmd_sched
    import cmd_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int RSP_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CMD_W-1:0] req_cmd,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [CMD_W-1:0]       rsp_data,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic                   run,
    output logic [CMD_W-1:0]       cmd,
    input  logic [CMD_W-1:0]       exe_rsp,
    output logic                   busy
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [3:0] LAT_LAST = 4'(RSP_LAT - 1);

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    win_idx;
    logic [N_REQ-1:0] win_grant;
    logic [3:0]       lat_cnt;
    logic [CMD_W-1:0] req_cmd_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_cmd_split
        assign req_cmd_a[i] = req_cmd[CMD_W*i +: CMD_W];
    end

    cmd_sched_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (state == S_IDLE),
        .grant (win_grant),
        .idx   (win_idx)
    );

    assign req_ready = win_grant;
    assign busy      = (state != S_IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_cnt   <= '0;
            run       <= 1'b0;
            cmd       <= '0;
            rsp_data  <= '0;
            rsp_valid <= '0;
        end else begin
            run <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|win_grant) begin
                        cmd    <= req_cmd_a[win_idx];
                        owner  <= win_idx;
                        rr_ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        run    <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Executor response is valid in the cycle where the count
                    // reaches RSP_LAT-1; capture it on that cycle's closing edge.
                    if (lat_cnt == LAT_LAST) begin
                        rsp_data  <= exe_rsp;
                        rsp_valid <= N_REQ'(1) << owner;
                        lat_cnt   <= '0;
                        state     <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sched.sv
// Directed self-checking bench for cmd_sched: a RSP_LAT=1 instance with an
// echo executor stub and a RSP_LAT=3 instance with a delayed-response stub.
`timescale 1ns/1ps
module tb_cmd_sched;

    localparam logic [31:0] ERR_WORD = 32'hEBAD_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  req_valid = '0;
    logic [63:0] req_cmd = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_data, cmd;
    logic [1:0]  rsp_ready = '0;
    logic        run, busy;
    logic [31:0] exe_rsp = '0;

    logic [1:0]  req_valid3 = '0;
    logic [63:0] req_cmd3 = '0;
    logic [1:0]  req_ready3, rsp_valid3;
    logic [31:0] rsp_data3, cmd3;
    logic [1:0]  rsp_ready3 = '0;
    logic        run3, busy3;
    logic [31:0] exe_rsp3 = '0;
    int          dly3 = 0;

    always #5 clk = ~clk;

    cmd_sched #(.N_REQ(2), .RSP_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .run(run), .cmd(cmd), .exe_rsp(exe_rsp), .busy(busy)
    );

    cmd_sched #(.N_REQ(2), .RSP_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_cmd(req_cmd3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .rsp_ready(rsp_ready3), .run(run3), .cmd(cmd3), .exe_rsp(exe_rsp3), .busy(busy3)
    );

    // Echo executor: responds one cycle after run; opcode 0xFF is unknown.
    always @(posedge clk) begin
        if (run) exe_rsp <= (cmd[31:24] == 8'hFF) ? ERR_WORD : cmd;
    end

    // Slow executor: stale value right after run, real result exactly 3 cycles after run.
    always @(posedge clk) begin
        if (run3) begin
            dly3     <= 1;
            exe_rsp3 <= 32'h5555_5555;
        end else if (dly3 == 2) begin
            dly3     <= 0;
            exe_rsp3 <= 32'hDEAD_BEEF;
        end else if (dly3 != 0) begin
            dly3 <= dly3 + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({run, cmd, rsp_data, rsp_valid, busy, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_state: run=%b cmd=%h rsp_data=%h rsp_valid=%b busy=%b req_ready=%b, required all 0",
                     run, cmd, rsp_data, rsp_valid, busy, req_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_cmd[31:0] = 32'h0000_0123;
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL single_grant: req_ready=%b required 01", req_ready);
        end
        step();  // cycle 1
        req_valid = 2'b00;
        checks++;
        if (run !== 1'b1 || cmd !== 32'h0000_0123 || busy !== 1'b1) begin
            failures++; $display("FAIL single_run: run=%b cmd=%h busy=%b required 1/00000123/1", run, cmd, busy);
        end
        step();  // cycle 2
        checks++;
        if (run !== 1'b0 || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL single_wait: run=%b rsp_valid=%b required 0/00", run, rsp_valid);
        end
        step();  // cycle 3
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_0123) begin
            failures++; $display("FAIL single_rsp: rsp_valid=%b rsp_data=%h required 01/00000123", rsp_valid, rsp_data);
        end
        step();  // cycle 4
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL single_done: rsp_valid=%b busy=%b required 00/0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int ng, nr, last_run;
        logic [1:0]  exp_g;
        logic [31:0] exp_c;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        ng = 0; nr = 0; last_run = -1;
        req_cmd = {32'h0000_000B, 32'h0000_000A};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready !== 2'b00 && ng < 4) begin
                exp_g = (ng % 2 == 1) ? 2'b10 : 2'b01;
                checks++;
                if (req_ready !== exp_g) begin
                    failures++; $display("FAIL b2b_grant%0d: req_ready=%b required %b", ng, req_ready, exp_g);
                end
                ng++;
            end
            if (run === 1'b1) begin
                if (nr < 4) begin
                    exp_c = (nr % 2 == 1) ? 32'h0000_000B : 32'h0000_000A;
                    checks++;
                    if (cmd !== exp_c) begin
                        failures++; $display("FAIL b2b_cmd%0d: cmd=%h required %h", nr, cmd, exp_c);
                    end
                end
                if (last_run >= 0) begin
                    checks++;
                    if (c - last_run != 4) begin
                        failures++; $display("FAIL b2b_spacing: run gap=%0d required 4", c - last_run);
                    end
                end
                last_run = c;
                nr++;
            end
            step();
        end
        checks++;
        if (ng != 4 || nr != 5) begin
            failures++; $display("FAIL b2b_count: grants=%0d runs=%0d required 4/5", ng, nr);
        end
        req_valid = 2'b00;
        wait_idle();
    endtask

    task automatic test_lat3();
        int c;
        req_cmd3[31:0] = 32'h0000_0003;
        req_valid3 = 2'b01;
        rsp_ready3 = 2'b11;
        #1;
        checks++;
        if (req_ready3 !== 2'b01) begin
            failures++; $display("FAIL lat3_grant: req_ready=%b required 01", req_ready3);
        end
        step();
        req_valid3 = 2'b00;
        c = 1;
        while (rsp_valid3 === 2'b00 && c < 20) begin
            step();
            c++;
        end
        checks++;
        if (c != 5 || rsp_valid3 !== 2'b01) begin
            failures++; $display("FAIL lat3_latency: rsp_valid=%b at cycle %0d, required 01 at cycle 5", rsp_valid3, c);
        end
        checks++;
        if (rsp_data3 !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL lat3_data: rsp_data=%h required deadbeef", rsp_data3);
        end
        step();
    endtask

    task automatic test_backpressure();
        req_cmd[31:0] = 32'h0000_0055;
        req_valid = 2'b01;
        rsp_ready = 2'b10;  // only the non-owner is ready
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL bp_grant0: req_ready=%b required 01", req_ready);
        end
        step();
        req_cmd[63:32] = 32'h0000_0066;
        req_valid = 2'b10;
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_0055 || req_ready !== 2'b00 || run !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: rsp_valid=%b rsp_data=%h req_ready=%b run=%b required 01/00000055/00/0",
                         c, rsp_valid, rsp_data, req_ready, run);
            end
            step();
        end
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            failures++; $display("FAIL bp_handshake: req_ready=%b required 00", req_ready);
        end
        step();
        checks++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL bp_grant1: req_ready=%b rsp_valid=%b required 10/00", req_ready, rsp_valid);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (run !== 1'b1 || cmd !== 32'h0000_0066) begin
            failures++; $display("FAIL bp_run1: run=%b cmd=%h required 1/00000066", run, cmd);
        end
        step();
        step();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'h0000_0066) begin
            failures++; $display("FAIL bp_rsp1: rsp_valid=%b rsp_data=%h required 10/00000066", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_error();
        req_cmd[63:32] = 32'hFF00_0042;
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++; $display("FAIL err_grant: req_ready=%b required 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        step();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== ERR_WORD) begin
            failures++; $display("FAIL err_rsp: rsp_valid=%b rsp_data=%h required 10/%h", rsp_valid, rsp_data, ERR_WORD);
        end
        step();
    endtask

    task automatic test_reset_mid();
        req_cmd[31:0] = 32'h0000_0077;
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        #1;
        step();  // ISSUE
        req_valid = 2'b00;
        step();  // WAIT
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL rmid_busy: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({run, cmd, rsp_data, rsp_valid, busy, req_ready} !== '0) begin
            failures++;
            $display("FAIL rmid_reset: run=%b cmd=%h rsp_data=%h rsp_valid=%b busy=%b req_ready=%b, required all 0",
                     run, cmd, rsp_data, rsp_valid, busy, req_ready);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                failures++; $display("FAIL rmid_quiet%0d: rsp_valid=%b busy=%b required 00/0", c, rsp_valid, busy);
            end
            step();
        end
        req_cmd = {32'h0000_0088, 32'h0000_0099};
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL rmid_ptr: req_ready=%b required 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (run !== 1'b1 || cmd !== 32'h0000_0099) begin
            failures++; $display("FAIL rmid_run: run=%b cmd=%h required 1/00000099", run, cmd);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lat3();
        test_backpressure();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
